poly_basemul: RTL and testbench

Pointwise multiplication of two Kyber polynomials in the NTT domain, computing r = a ∘ b as 128 degree-1 products modulo (X² − ζ). It sits directly downstream of the forward NTT. It reads the two transformed operand polynomials from coefficient RAMs, fetches zetas from the shared zeta ROM, and writes the product polynomial to a result RAM for the subsequent INTT. It uses one time-shared Montgomery multiplier, fully internal.

---
 rtl/poly_basemul.sv | 200 ++++++++++++++++++++
 tb/tb_poly_basemul.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/poly_basemul.sv
// rtl/poly_basemul.sv - Kyber NTT-domain pointwise multiply, one shared Montgomery multiplier
module poly_basemul #(
  parameter int KYBER_N = 256,
  parameter int KYBER_Q = 3329,
  parameter int QINV    = 62209
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [15:0] A_RData,
  output logic [7:0]  A_RAd,
  input  logic [15:0] B_RData,
  output logic [7:0]  B_RAd,
  output logic [6:0]  Zeta_RAd,
  input  logic [15:0] Zeta_RData,
  output logic        R_WEN,
  output logic [7:0]  R_WAd,
  output logic [15:0] R_WData,
  output logic        busy,
  output logic        done
);

  localparam logic [15:0] QINV16    = 16'(QINV);
  localparam logic [31:0] Q32       = 32'(KYBER_Q);
  localparam logic [6:0]  LAST_PAIR = 7'(KYBER_N / 2 - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_RD0, S_RD1, S_CAP, S_M0, S_M1, S_M2, S_M3, S_M4, S_W0, S_W1
  } state_t;

  // Montgomery product: x*y*2^-16 mod q, low 16 bits of the exact shifted difference
  function automatic logic [15:0] fqmul(input logic [15:0] x, input logic [15:0] y);
    logic [31:0] prod;
    logic [15:0] t;
    logic [31:0] tq;
    prod = {{16{x[15]}}, x} * {{16{y[15]}}, y};
    t = prod[15:0] * QINV16;
    tq = {{16{t[15]}}, t} * Q32;
    fqmul = 16'((prod - tq) >> 16);
  endfunction

  state_t      state_q, state_d;
  logic [6:0]  p_q, p_d;
  logic [15:0] a0_q, a0_d, a1_q, a1_d, b0_q, b0_d, b1_q, b1_d;
  logic [15:0] zeta_q, zeta_d, t_q, t_d, r0_q, r0_d, r1_q, r1_d;
  logic [7:0]  a_rad_q, a_rad_d, r_wad_q, r_wad_d;
  logic [6:0]  zeta_rad_q, zeta_rad_d;
  logic        r_wen_q, r_wen_d, busy_q, busy_d, done_q, done_d;
  logic [15:0] r_wdata_q, r_wdata_d;
  logic [15:0] mul_x, mul_y, mul_r, zeta_eff;

  // State, datapath and registered outputs; reset returns everything to idle at once
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      p_q        <= '0;
      a0_q       <= '0;
      a1_q       <= '0;
      b0_q       <= '0;
      b1_q       <= '0;
      zeta_q     <= '0;
      t_q        <= '0;
      r0_q       <= '0;
      r1_q       <= '0;
      a_rad_q    <= '0;
      zeta_rad_q <= '0;
      r_wen_q    <= 1'b0;
      r_wad_q    <= '0;
      r_wdata_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      p_q        <= p_d;
      a0_q       <= a0_d;
      a1_q       <= a1_d;
      b0_q       <= b0_d;
      b1_q       <= b1_d;
      zeta_q     <= zeta_d;
      t_q        <= t_d;
      r0_q       <= r0_d;
      r1_q       <= r1_d;
      a_rad_q    <= a_rad_d;
      zeta_rad_q <= zeta_rad_d;
      r_wen_q    <= r_wen_d;
      r_wad_q    <= r_wad_d;
      r_wdata_q  <= r_wdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next state: fixed 10-cycle walk per pair, back to IDLE after the last pair
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (enable) state_d = S_RD0;
      S_RD0:   state_d = S_RD1;
      S_RD1:   state_d = S_CAP;
      S_CAP:   state_d = S_M0;
      S_M0:    state_d = S_M1;
      S_M1:    state_d = S_M2;
      S_M2:    state_d = S_M3;
      S_M3:    state_d = S_M4;
      S_M4:    state_d = S_W0;
      S_W0:    state_d = S_W1;
      S_W1:    state_d = (p_q == LAST_PAIR) ? S_IDLE : S_RD0;
      default: state_d = S_IDLE;
    endcase
  end

  // Multiplier operand select; odd pairs use the negated zeta
  always_comb begin
    zeta_eff = p_q[0] ? (16'd0 - zeta_q) : zeta_q;
    mul_x = '0;
    mul_y = '0;
    case (state_q)
      S_M0: begin mul_x = a1_q; mul_y = b1_q;     end
      S_M1: begin mul_x = t_q;  mul_y = zeta_eff; end
      S_M2: begin mul_x = a0_q; mul_y = b0_q;     end
      S_M3: begin mul_x = a0_q; mul_y = b1_q;     end
      S_M4: begin mul_x = a1_q; mul_y = b0_q;     end
      default: ;
    endcase
    mul_r = fqmul(mul_x, mul_y);
  end

  // Outputs and captures: outputs are set from the state being entered so they are registered
  always_comb begin
    p_d        = p_q;
    a0_d       = a0_q;
    a1_d       = a1_q;
    b0_d       = b0_q;
    b1_d       = b1_q;
    zeta_d     = zeta_q;
    t_d        = t_q;
    r0_d       = r0_q;
    r1_d       = r1_q;
    a_rad_d    = a_rad_q;
    zeta_rad_d = zeta_rad_q;
    r_wen_d    = 1'b0;
    r_wad_d    = r_wad_q;
    r_wdata_d  = r_wdata_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: if (enable) begin
        busy_d = 1'b1;
        p_d    = '0;
      end
      S_RD1: begin a0_d = A_RData; b0_d = B_RData; zeta_d = Zeta_RData; end
      S_CAP: begin a1_d = A_RData; b1_d = B_RData; end
      S_M0:  t_d  = mul_r;
      S_M1:  t_d  = mul_r;
      S_M2:  r0_d = t_q + mul_r;
      S_M3:  r1_d = mul_r;
      S_M4:  r1_d = r1_q + mul_r;
      S_W1: begin
        if (p_q == LAST_PAIR) begin
          p_d    = '0;
          busy_d = 1'b0;
          done_d = 1'b1;
        end else begin
          p_d = p_q + 7'd1;
        end
      end
      default: ;
    endcase

    case (state_d)
      S_RD0: begin
        a_rad_d    = {p_d, 1'b0};
        zeta_rad_d = {1'b1, p_d[6:1]};
      end
      S_RD1: a_rad_d = {p_q, 1'b1};
      S_W0: begin
        r_wen_d   = 1'b1;
        r_wad_d   = {p_q, 1'b0};
        r_wdata_d = r0_q;
      end
      S_W1: begin
        r_wen_d   = 1'b1;
        r_wad_d   = {p_q, 1'b1};
        r_wdata_d = r1_q;
      end
      default: ;
    endcase
  end

  assign A_RAd    = a_rad_q;
  assign B_RAd    = a_rad_q;
  assign Zeta_RAd = zeta_rad_q;
  assign R_WEN    = r_wen_q;
  assign R_WAd    = r_wad_q;
  assign R_WData  = r_wdata_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_poly_basemul.sv
// tb/tb_poly_basemul.sv - scoreboard bench for poly_basemul against a C-style basemul model
module tb_poly_basemul;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [15:0] A_RData, B_RData, Zeta_RData;
  logic [7:0]  A_RAd, B_RAd, R_WAd;
  logic [6:0]  Zeta_RAd;
  logic        R_WEN, busy, done;
  logic [15:0] R_WData;

  poly_basemul dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .A_RData(A_RData), .A_RAd(A_RAd),
    .B_RData(B_RData), .B_RAd(B_RAd),
    .Zeta_RAd(Zeta_RAd), .Zeta_RData(Zeta_RData),
    .R_WEN(R_WEN), .R_WAd(R_WAd), .R_WData(R_WData),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  shortint zetas [0:127] = '{
    -1044,  -758,  -359, -1517,  1493,  1422,   287,   202,
     -171,   622,  1577,   182,   962, -1202, -1474,  1468,
      573, -1325,   264,   383,  -829,  1458, -1602,  -130,
     -681,  1017,   732,   608, -1542,   411,  -205, -1571,
     1223,   652,  -552,  1015, -1293,  1491,  -282, -1544,
      516,    -8,  -320,  -666, -1618, -1162,   126,  1469,
     -853,   -90,  -271,   830,   107, -1421,  -247,  -951,
     -398,   961, -1508,  -725,   448, -1065,   677, -1275,
    -1103,   430,   555,   843, -1251,   871,  1550,   105,
      422,   587,   177,  -235,  -291,  -460,  1574,  1653,
     -246,   778,  1159,  -147,  -777,  1483,  -602,  1119,
    -1590,   644,  -872,   349,   418,   329,  -156,   -75,
      817,  1097,   603,   610,  1322, -1285, -1465,   384,
    -1215,  -136,  1218, -1335,  -874,   220, -1187, -1659,
    -1185, -1530, -1278,   794, -1510,  -854,  -870,   478,
     -108,  -308,   996,   991,   958, -1460,  1522,  1628
  };

  logic [15:0] a_init   [0:255];
  logic [15:0] a_mem    [0:255];
  logic [15:0] b_mem    [0:255];
  logic [15:0] zeta_rom [0:127];
  logic        load;
  logic        alias_a;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;
  wr_t exp_q[$];
  wr_t mon_e;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at %0t", nm, act, act, expv, expv, $time);
    end
  endtask

  // Synchronous-read RAMs; RAM a also takes result writes when r aliases a
  always @(posedge clk) begin
    A_RData    <= a_mem[A_RAd];
    B_RData    <= b_mem[B_RAd];
    Zeta_RData <= zeta_rom[Zeta_RAd];
    if (load) a_mem <= a_init;
    else if (R_WEN && alias_a) a_mem[R_WAd] <= R_WData;
  end

  // Monitor: every write is popped against the scoreboard
  always @(negedge clk) begin
    if (reset_n && R_WEN) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: addr %0d data 0x%0h with empty scoreboard", R_WAd, R_WData);
      end else begin
        mon_e = exp_q.pop_front();
        check("write_addr", 32'(R_WAd), 32'(mon_e.addr));
        check("write_data", 32'(R_WData), 32'(mon_e.data));
      end
    end
  end

  function automatic shortint fqmul(input shortint x, input shortint y);
    int prod;
    shortint t;
    int diff;
    prod = int'(x) * int'(y);
    t = shortint'(prod * 62209);
    diff = prod - int'(t) * 3329;
    return shortint'(diff >>> 16);
  endfunction

  task automatic push_exp(input int addr, input logic [15:0] data);
    wr_t e;
    e.addr = 8'(addr);
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Reference basemul over the loaded operands, pushed in write order
  task automatic push_model();
    shortint a0, a1, b0, b1, z, r0, r1;
    for (int p = 0; p < 128; p++) begin
      a0 = shortint'(a_init[2*p]);
      a1 = shortint'(a_init[2*p+1]);
      b0 = shortint'(b_mem[2*p]);
      b1 = shortint'(b_mem[2*p+1]);
      z  = shortint'(zeta_rom[64 + p/2]);
      if (p % 2 == 1) z = shortint'(-int'(z));
      r0 = shortint'(int'(fqmul(fqmul(a1, b1), z)) + int'(fqmul(a0, b0)));
      r1 = shortint'(int'(fqmul(a0, b1)) + int'(fqmul(a1, b0)));
      push_exp(2*p, 16'(r0));
      push_exp(2*p+1, 16'(r1));
    end
  endtask

  task automatic do_load();
    @(negedge clk);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic randomize_ops();
    for (int i = 0; i < 256; i++) begin
      a_init[i] = 16'($urandom_range(0, 6656)) - 16'd3328;
      b_mem[i]  = 16'($urandom_range(0, 6656)) - 16'd3328;
    end
  endtask

  task automatic real_zetas();
    for (int i = 0; i < 128; i++) zeta_rom[i] = 16'(zetas[i]);
  endtask

  // One run: enable sampled at the first edge; extra_en injects a pulse while busy, rst_at aborts
  task automatic run(input int extra_en, input int rst_at);
    int done_at;
    int n_done;
    int busy_cnt;
    done_at = -1;
    n_done = 0;
    busy_cnt = 0;
    @(negedge clk);
    #2 enable = 1'b1;
    @(posedge clk);
    #1 enable = 1'b0;
    for (int c = 1; c <= 1300; c++) begin
      @(negedge clk);
      #2;
      enable = (c == extra_en);
      if (c == rst_at) begin
        check("wen_before_reset", 32'(R_WEN), 32'd1);
        reset_n = 1'b0;
        #1;
        check("reset_wen", 32'(R_WEN), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_wad", 32'(R_WAd), 32'd0);
        check("reset_rad", 32'(A_RAd), 32'd0);
        enable = 1'b0;
        exp_q.delete();
        return;
      end
      if (busy) busy_cnt++;
      if (done) begin
        n_done++;
        if (done_at < 0) done_at = c;
      end
    end
    check("done_cycle", 32'(done_at), 32'd1281);
    check("done_pulses", 32'(n_done), 32'd1);
    check("busy_cycles", 32'(busy_cnt), 32'd1280);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    enable  = 1'b0;
    load    = 1'b0;
    alias_a = 1'b0;
    real_zetas();
    for (int i = 0; i < 256; i++) begin
      a_init[i] = '0;
      b_mem[i]  = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_A_RAd", 32'(A_RAd), 32'd0);
    check("rst_B_RAd", 32'(B_RAd), 32'd0);
    check("rst_Zeta_RAd", 32'(Zeta_RAd), 32'd0);
    check("rst_R_WEN", 32'(R_WEN), 32'd0);
    check("rst_R_WAd", 32'(R_WAd), 32'd0);
    check("rst_R_WData", 32'(R_WData), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // All-zero operands: 256 zero writes in address order
    do_load();
    for (int i = 0; i < 256; i++) push_exp(i, 16'h0000);
    run(0, 0);

    // a0=b0=Montgomery one, a1=b1=0
    for (int p = 0; p < 128; p++) begin
      a_init[2*p] = 16'd2285; a_init[2*p+1] = 16'd0;
      b_mem[2*p]  = 16'd2285; b_mem[2*p+1]  = 16'd0;
    end
    do_load();
    for (int p = 0; p < 128; p++) begin
      push_exp(2*p, 16'hFBEC);
      push_exp(2*p+1, 16'h0000);
    end
    run(0, 0);

    // a1=b1=Montgomery one, zeta ROM constant: sign of r[2p] follows pair parity
    for (int p = 0; p < 128; p++) begin
      a_init[2*p] = 16'd0; a_init[2*p+1] = 16'd2285;
      b_mem[2*p]  = 16'd0; b_mem[2*p+1]  = 16'd2285;
      zeta_rom[p] = 16'd2285;
    end
    do_load();
    for (int p = 0; p < 128; p++) begin
      push_exp(2*p, (p % 2 == 0) ? 16'hFBEC : 16'h0414);
      push_exp(2*p+1, 16'h0000);
    end
    run(0, 0);
    real_zetas();

    // Random operands with a second enable while busy (must be ignored)
    randomize_ops();
    do_load();
    push_model();
    run(700, 0);

    // Random operands, result written in place over RAM a
    randomize_ops();
    alias_a = 1'b1;
    do_load();
    push_model();
    run(0, 0);
    alias_a = 1'b0;

    // Reset in the middle of a run (cycle 500 is a W1 write cycle)
    randomize_ops();
    do_load();
    push_model();
    run(0, 500);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (30) @(negedge clk);
    #2;
    check("idle_after_reset_busy", 32'(busy), 32'd0);
    check("idle_after_reset_wen", 32'(R_WEN), 32'd0);

    // Full run after reset recovery
    randomize_ops();
    do_load();
    push_model();
    run(0, 0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
